// File: rtl/secure_memory_pkg.sv
// rtl/secure_memory_pkg.sv - shared types and constants for the secure memory arbiter
package secure_memory_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT,
    DONE
  } state_t;

  localparam logic [31:0] DEFAULT_XOR_KEY   = 32'h95DA4EAB;
  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h8000;
  localparam int          WORD_SHIFT        = 2;

  // Byte address to memory word index; wraps mod 2^16 with no range check.
  function automatic logic [15:0] word_addr(input logic [15:0] byte_addr,
                                            input logic [15:0] base);
    logic [15:0] offset;
    offset = byte_addr - base;
    return offset >> WORD_SHIFT;
  endfunction

endpackage

// File: rtl/secure_memory_req_slot.sv
// rtl/secure_memory_req_slot.sv - per-port request latch plus registered completion outputs
module secure_memory_req_slot
  import secure_memory_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        write,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  input  logic        finish,
  input  logic        abort,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        clear,
  output logic        pending,
  output logic        req_write,
  output logic [15:0] req_addr,
  output logic [31:0] req_wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= 1'b0;
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      // A start while a request is already held is dropped on purpose.
      if (start && !pending) begin
        pending   <= 1'b1;
        req_write <= write;
        req_addr  <= addr;
        req_wdata <= wdata;
      end else if (clear) begin
        pending <= 1'b0;
      end
      done <= finish;
      err  <= finish && abort;
      if (load) begin
        rdata <= load_data;
      end
    end
  end

endmodule

// File: rtl/secure_memory_arbiter.sv
// rtl/secure_memory_arbiter.sv - two-port round-robin arbiter onto the scrambled secure memory bus
module secure_memory_arbiter
  import secure_memory_pkg::*;
#(
  parameter logic [31:0] XOR_KEY   = DEFAULT_XOR_KEY,
  parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_start,
  input  logic        req0_write,
  input  logic [15:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_done,
  output logic        req0_err,
  output logic [31:0] req0_rdata,
  input  logic        req1_start,
  input  logic        req1_write,
  input  logic [15:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_done,
  output logic        req1_err,
  output logic [31:0] req1_rdata,
  output logic [15:0] address,
  output logic [3:0]  byteenable,
  output logic        chipselect,
  output logic        write,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);

  state_t      state;
  logic        grant;
  logic        last_grant;
  logic [7:0]  stall_cnt;

  logic        pend0, pend1, wr0, wr1;
  logic [15:0] addr0, addr1;
  logic [31:0] wd0, wd1;

  logic        sel_write;
  logic [15:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        timed_out, finish_any, pick;

  assign sel_write  = grant ? wr1 : wr0;
  assign sel_addr   = grant ? addr1 : addr0;
  assign sel_wdata  = grant ? wd1 : wd0;
  assign timed_out  = (state == ACCESS) && waitrequest && (stall_cnt == STALL_LIMIT);
  assign finish_any = ((state == ACCESS) && !waitrequest && sel_write) || timed_out ||
                      (state == RDWAIT);
  // last_grant only moves on a contested decision, so back-to-back pairs alternate.
  assign pick       = (pend0 && pend1) ? ~last_grant : pend1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      stall_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend0 || pend1) begin
            grant <= pick;
            if (pend0 && pend1) begin
              last_grant <= pick;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          if (!waitrequest) begin
            stall_cnt <= '0;
            state     <= sel_write ? DONE : RDWAIT;
          end else if (stall_cnt == STALL_LIMIT) begin
            stall_cnt <= '0;
            state     <= DONE;
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end
        RDWAIT: state <= DONE;
        DONE: begin
          // The waiting port goes straight onto the bus without an idle gap.
          if (grant ? pend0 : pend1) begin
            grant <= ~grant;
            state <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    chipselect = 1'b0;
    byteenable = 4'h0;
    address    = '0;
    write      = 1'b0;
    writedata  = '0;
    if (state == ACCESS) begin
      chipselect = 1'b1;
      byteenable = 4'hF;
      address    = word_addr(sel_addr, BASE_ADDR);
      write      = sel_write;
      writedata  = sel_write ? (sel_wdata ^ XOR_KEY) : 32'h0;
    end
  end

  secure_memory_req_slot u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .start     (req0_start),
    .write     (req0_write),
    .addr      (req0_addr),
    .wdata     (req0_wdata),
    .finish    (finish_any && !grant),
    .abort     (timed_out),
    .load      ((state == RDWAIT) && !grant),
    .load_data (readdata ^ XOR_KEY),
    .clear     ((state == DONE) && !grant),
    .pending   (pend0),
    .req_write (wr0),
    .req_addr  (addr0),
    .req_wdata (wd0),
    .done      (req0_done),
    .err       (req0_err),
    .rdata     (req0_rdata)
  );

  secure_memory_req_slot u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .start     (req1_start),
    .write     (req1_write),
    .addr      (req1_addr),
    .wdata     (req1_wdata),
    .finish    (finish_any && grant),
    .abort     (timed_out),
    .load      ((state == RDWAIT) && grant),
    .load_data (readdata ^ XOR_KEY),
    .clear     ((state == DONE) && grant),
    .pending   (pend1),
    .req_write (wr1),
    .req_addr  (addr1),
    .req_wdata (wd1),
    .done      (req1_done),
    .err       (req1_err),
    .rdata     (req1_rdata)
  );

endmodule

// File: tb/tb_secure_memory_arbiter.sv
// tb/tb_secure_memory_arbiter.sv - self-checking bench for secure_memory_arbiter
module tb_secure_memory_arbiter;

  localparam logic [31:0] KEY  = 32'h95DA4EAB;
  localparam logic [15:0] BASE = 16'h8000;
  localparam int          TMO  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_start = 0, req0_write = 0, req1_start = 0, req1_write = 0;
  logic [15:0] req0_addr = 0, req1_addr = 0;
  logic [31:0] req0_wdata = 0, req1_wdata = 0;
  logic        req0_done, req0_err, req1_done, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic [15:0] address;
  logic [3:0]  byteenable;
  logic        chipselect, write;
  logic [31:0] writedata;
  logic [31:0] readdata = 0;
  logic        waitrequest = 0;

  secure_memory_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .req0_start(req0_start), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_err(req0_err),
    .req0_rdata(req0_rdata),
    .req1_start(req1_start), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_err(req1_err),
    .req1_rdata(req1_rdata),
    .address(address), .byteenable(byteenable), .chipselect(chipselect),
    .write(write), .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Transaction-level reference: pending requests, round-robin choice, scrambling.
  logic [1:0]  mreg = 2'b00;
  logic [1:0]  cand_prev = 2'b00;
  logic        m_last = 1'b1;
  logic        cur_valid = 1'b0;
  int          cur_port = 0;
  int          stalls = 0;
  logic        cur_acc = 1'b0;
  logic        acc_read = 1'b0;
  logic [31:0] rd_val = 0;
  logic [31:0] exp_rdata [2] = '{32'h0, 32'h0};
  logic        m_write [2] = '{1'b0, 1'b0};
  logic [15:0] m_addr [2] = '{16'h0, 16'h0};
  logic [31:0] m_wdata [2] = '{32'h0, 32'h0};

  always @(negedge clk) begin : model
    logic [1:0]  dn, st, cap, er;
    int          ep;
    logic [15:0] ea;
    logic [31:0] ew;
    logic        ee;
    dn = {req1_done, req0_done};
    er = {req1_err, req0_err};
    st = {req1_start, req0_start};
    if (acc_read) begin
      rd_val   = readdata;
      acc_read = 1'b0;
    end
    if (chipselect) begin
      if (!cur_valid) begin
        ep = 0;
        if (cand_prev == 2'b11) begin
          ep     = m_last ? 0 : 1;
          m_last = (ep == 1);
        end else if (cand_prev[1]) ep = 1;
        else if (cand_prev[0]) ep = 0;
        else flag("bus_without_request");
        cur_valid = 1'b1;
        cur_port  = ep;
        stalls    = 0;
        cur_acc   = 1'b0;
      end
      ea = m_addr[cur_port] - BASE;
      ea = ea >> 2;
      ew = m_write[cur_port] ? (m_wdata[cur_port] ^ KEY) : 32'h0;
      chk("bus_addr", address, ea);
      chk("bus_write", write, m_write[cur_port]);
      chk("bus_wdata", writedata, ew);
      chk("bus_be", byteenable, 4'hF);
      if (waitrequest) begin
        if (stalls >= TMO) flag("stall_past_timeout");
        stalls++;
      end else if (!cur_acc) begin
        cur_acc = 1'b1;
        if (!m_write[cur_port]) acc_read = 1'b1;
      end
    end else begin
      chk("bus_idle_ctl", {address, byteenable, write}, 32'h0);
      chk("bus_idle_wdata", writedata, 32'h0);
    end
    if (dn == 2'b11) flag("double_done");
    for (int p = 0; p < 2; p++) begin
      if (dn[p]) begin
        chk("done_port", cur_valid ? cur_port : 9, p);
        ee = cur_valid && !cur_acc;
        if (ee) chk("timeout_len", stalls, TMO);
        chk("done_err", er[p], ee);
        if (cur_valid && cur_acc && cur_port == p && !m_write[p]) exp_rdata[p] = rd_val ^ KEY;
        cur_valid = 1'b0;
      end
    end
    chk("rdata0", req0_rdata, exp_rdata[0]);
    chk("rdata1", req1_rdata, exp_rdata[1]);
    cap = st & ~mreg;
    if (cap[0]) begin m_write[0] = req0_write; m_addr[0] = req0_addr; m_wdata[0] = req0_wdata; end
    if (cap[1]) begin m_write[1] = req1_write; m_addr[1] = req1_addr; m_wdata[1] = req1_wdata; end
    cand_prev = mreg & ~dn;
    mreg      = (mreg & ~dn) | cap;
    if (reset) begin
      mreg      = 2'b00;
      cand_prev = 2'b00;
      m_last    = 1'b1;
      cur_valid = 1'b0;
      acc_read  = 1'b0;
      exp_rdata = '{32'h0, 32'h0};
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    next_cycle();
    req0_start = 1'b0;
    req1_start = 1'b0;
  endtask

  task automatic drive(input int p, input logic wr, input logic [15:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0_start = 1'b1; req0_write = wr; req0_addr = a; req0_wdata = d;
    end else begin
      req1_start = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic at_cycle(input int n);
    int k;
    k = 0;
    @(negedge clk);
    while (cyc != n && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (cyc != n) begin
      checks++;
      failures++;
      $display("FAIL at_cycle_bound actual=%0d required=%0d", cyc, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    t = cyc;
    at_cycle(t);
    chk("rst_bus_ctl", {chipselect, write, byteenable}, 32'h0);
    chk("rst_addr", address, 32'h0);
    chk("rst_wdata", writedata, 32'h0);
    chk("rst_done_err", {req0_done, req1_done, req0_err, req1_err}, 32'h0);
    chk("rst_rdata0", req0_rdata, 32'h0);
    chk("rst_rdata1", req1_rdata, 32'h0);

    // simultaneous starts straight after reset: port 0 first
    next_cycle();
    t = cyc;
    drive(0, 1'b1, 16'h8000, 32'h11);
    drive(1, 1'b1, 16'h8020, 32'h22);
    step();
    at_cycle(t + 2); chk("pair1_first_addr", address, 16'h0000); chk("pair1_first_cs", chipselect, 1'b1);
    at_cycle(t + 3); chk("pair1_done0", req0_done, 1'b1); chk("pair1_gap_cs", chipselect, 1'b0);
    at_cycle(t + 4); chk("pair1_second_cs", chipselect, 1'b1); chk("pair1_second_addr", address, 16'h0008);
    at_cycle(t + 5); chk("pair1_done1", req1_done, 1'b1);

    // second simultaneous pair: port 1 first
    next_cycle();
    t = cyc;
    drive(0, 1'b1, 16'h8004, 32'h33);
    drive(1, 1'b1, 16'h800C, 32'h44);
    step();
    at_cycle(t + 2); chk("pair2_first_addr", address, 16'h0003);
    at_cycle(t + 3); chk("pair2_done1", req1_done, 1'b1);
    at_cycle(t + 4); chk("pair2_second_addr", address, 16'h0001);
    at_cycle(t + 5); chk("pair2_done0", req0_done, 1'b1);

    // port 0 write, no stall
    next_cycle();
    t = cyc;
    drive(0, 1'b1, 16'h8010, 32'h00000000);
    step();
    at_cycle(t + 2);
    chk("wr_addr", address, 16'h0004);
    chk("wr_write", write, 1'b1);
    chk("wr_wdata", writedata, 32'h95DA4EAB);
    chk("wr_be", byteenable, 4'hF);
    chk("wr_done_early", req0_done, 1'b0);
    at_cycle(t + 3); chk("wr_done", req0_done, 1'b1); chk("wr_err", req0_err, 1'b0);

    // port 1 read; a repeated start while pending is ignored
    next_cycle();
    readdata = 32'h95DA4EAB;
    t = cyc;
    drive(1, 1'b0, 16'h8010, 32'h0);
    step();
    drive(1, 1'b1, 16'h8100, 32'hDEAD);
    step();
    at_cycle(t + 2); chk("rd_addr", address, 16'h0004); chk("rd_write", write, 1'b0); chk("rd_wdata", writedata, 32'h0);
    at_cycle(t + 3); chk("rd_done_early", req1_done, 1'b0);
    at_cycle(t + 4); chk("rd_done", req1_done, 1'b1); chk("rd_rdata", req1_rdata, 32'h00000000);
    at_cycle(t + 5); chk("rd_no_second_done", req1_done, 1'b0);

    next_cycle();
    readdata = 32'h12345678;
    t = cyc;
    drive(1, 1'b0, 16'h8020, 32'h0);
    step();
    at_cycle(t + 4); chk("rd2_done", req1_done, 1'b1); chk("rd2_rdata", req1_rdata, 32'h87EE18D3);
    at_cycle(t + 7); chk("rd2_rdata_held", req1_rdata, 32'h87EE18D3);

    // three waitrequest cycles on a write
    next_cycle();
    waitrequest = 1'b1;
    t = cyc;
    drive(0, 1'b1, 16'h8040, 32'h00000001);
    step();
    at_cycle(t + 3); chk("ws_addr", address, 16'h0010); chk("ws_wdata", writedata, 32'h95DA4EAA);
    at_cycle(t + 4); chk("ws_wdata_hold", writedata, 32'h95DA4EAA); chk("ws_cs_hold", chipselect, 1'b1);
    next_cycle();
    waitrequest = 1'b0;
    at_cycle(t + 5); chk("ws_done_early", req0_done, 1'b0);
    at_cycle(t + 6); chk("ws_done", req0_done, 1'b1); chk("ws_err", req0_err, 1'b0);

    // timeout on port 1 read while port 0 waits
    next_cycle();
    waitrequest = 1'b1;
    t = cyc;
    drive(1, 1'b0, 16'h8000, 32'h0);
    step();
    drive(0, 1'b1, 16'h8030, 32'h5);
    step();
    at_cycle(t + 5); chk("to_cs", chipselect, 1'b1); chk("to_addr", address, 16'h0000);
    at_cycle(t + 6); chk("to_done", req1_done, 1'b1); chk("to_err", req1_err, 1'b1);
    chk("to_rdata_kept", req1_rdata, 32'h87EE18D3);
    next_cycle();
    waitrequest = 1'b0;
    at_cycle(t + 7); chk("to_next_cs", chipselect, 1'b1); chk("to_next_addr", address, 16'h000C);
    at_cycle(t + 8); chk("to_next_done", req0_done, 1'b1); chk("to_next_err", req0_err, 1'b0);

    // reset during the ACCESS cycle of a read
    next_cycle();
    readdata = 32'hFFFFFFFF;
    t = cyc;
    drive(0, 1'b0, 16'h8000, 32'h0);
    step();
    next_cycle();
    reset = 1'b1;
    at_cycle(t + 2); chk("rst_mid_cs_before", chipselect, 1'b1);
    next_cycle();
    reset = 1'b0;
    at_cycle(t + 3);
    chk("rst_mid_bus", {chipselect, write, byteenable}, 32'h0);
    chk("rst_mid_done", req0_done, 1'b0);
    at_cycle(t + 4); chk("rst_mid_no_done", req0_done, 1'b0); chk("rst_mid_rdata", req0_rdata, 32'h0);
    next_cycle();
    t = cyc;
    drive(0, 1'b1, 16'h8008, 32'h7);
    step();
    at_cycle(t + 2); chk("post_rst_addr", address, 16'h0002);
    at_cycle(t + 3); chk("post_rst_done", req0_done, 1'b1);

    repeat (3) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
